// File: rtl/mu0_pkg.sv
// Shared encodings for the MU0 control unit: opcodes, FSM states, ALU codes,
// datapath mux selects and the bundled control vector.
package mu0_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_PASS_Y = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_INC    = 2'b10;
    localparam logic [1:0] ALU_SUB    = 2'b11;

    localparam logic SEL_ACC = 1'b0;
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_DIN = 1'b0;
    localparam logic SEL_IR  = 1'b1;
    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
        logic       halted;
    } ctrl_t;

    // Opcodes whose execute cycle touches memory (LDA, STA, ADD, SUB).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// Combinational decode of (state, opcode, N, Z) into the MU0 control vector
// and the next FSM state.
module mu0_ctrl_decode
    import mu0_pkg::*;
(
    input  state_t     i_state,
    input  logic [3:0] i_op,
    input  logic       i_n,
    input  logic       i_z,
    output ctrl_t      o_ctrl,
    output state_t     o_next
);

    logic w_take;

    assign w_take = (i_op == OP_JMP)
                 || ((i_op == OP_JGE) && !i_n)
                 || ((i_op == OP_JNE) && !i_z);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_ctrl = '0;
        o_next = ST_FETCH;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.addr_sel = ADDR_PC;
                o_ctrl.rd       = 1'b1;
                o_ctrl.ir_en    = 1'b1;
                o_ctrl.x_sel    = SEL_PC;
                o_ctrl.m        = ALU_INC;
                o_ctrl.pc_en    = 1'b1;
                o_next          = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (i_op)
                    OP_LDA: begin
                        o_ctrl.addr_sel = ADDR_IR;
                        o_ctrl.rd       = 1'b1;
                        o_ctrl.y_sel    = SEL_DIN;
                        o_ctrl.m        = ALU_PASS_Y;
                        o_ctrl.acc_en   = 1'b1;
                    end
                    OP_STA: begin
                        o_ctrl.addr_sel = ADDR_IR;
                        o_ctrl.wr       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.addr_sel = ADDR_IR;
                        o_ctrl.rd       = 1'b1;
                        o_ctrl.x_sel    = SEL_ACC;
                        o_ctrl.y_sel    = SEL_DIN;
                        o_ctrl.m        = (i_op == OP_SUB) ? ALU_SUB : ALU_ADD;
                        o_ctrl.acc_en   = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        // An untaken conditional jump leaves every control low.
                        if (w_take) begin
                            o_ctrl.y_sel = SEL_IR;
                            o_ctrl.m     = ALU_PASS_Y;
                            o_ctrl.pc_en = 1'b1;
                        end
                    end
                    OP_STP:  o_next = ST_HALT;
                    default: ;
                endcase
            end
            ST_HALT: begin
                o_ctrl.halted = 1'b1;
                o_next        = ST_HALT;
            end
            default: o_next = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/mu0_ctrl_fsm.sv
// MU0 control unit: state register plus decode. Define MU0_MEM_READY_EN to add
// the Mem_Rdy input that stalls memory cycles until the memory is ready.
module mu0_ctrl_fsm
    import mu0_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MW  = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [OPW-1:0] F,
    input  logic           N,
    input  logic           Z,
`ifdef MU0_MEM_READY_EN
    input  logic           Mem_Rdy,
`endif
    output logic           X_sel,
    output logic           Y_sel,
    output logic           Addr_sel,
    output logic           PC_En,
    output logic           IR_En,
    output logic           Acc_En,
    output logic [MW-1:0]  M,
    output logic           Rd,
    output logic           Wr,
    output logic           Halted
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_advance;

    mu0_ctrl_decode u_decode (
        .i_state (r_state),
        .i_op    (4'(F)),
        .i_n     (N),
        .i_z     (Z),
        .o_ctrl  (w_ctrl),
        .o_next  (w_next)
    );

`ifdef MU0_MEM_READY_EN
    logic w_mem_cycle;

    assign w_mem_cycle = (r_state == ST_FETCH)
                      || ((r_state == ST_EXECUTE) && is_mem_op(4'(F)));
    // A waiting memory cycle keeps its strobes but may not commit any register.
    assign w_advance   = !w_mem_cycle || Mem_Rdy;
`else
    assign w_advance   = 1'b1;
`endif

    assign X_sel    = w_ctrl.x_sel;
    assign Y_sel    = w_ctrl.y_sel;
    assign Addr_sel = w_ctrl.addr_sel;
    assign PC_En    = w_ctrl.pc_en  & w_advance;
    assign IR_En    = w_ctrl.ir_en  & w_advance;
    assign Acc_En   = w_ctrl.acc_en & w_advance;
    assign M        = MW'(w_ctrl.m);
    assign Rd       = w_ctrl.rd;
    assign Wr       = w_ctrl.wr;
    assign Halted   = w_ctrl.halted;

    always_ff @(posedge Clk) begin
        // NOTE: state uses non-blocking assignment so every reader sees the pre-edge value.
        if (Reset) begin
            r_state <= ST_FETCH;
        end else if (w_advance) begin
            r_state <= w_next;
        end
    end

endmodule

// File: tb/tb_mu0_ctrl_fsm.sv
// Self-checking bench for mu0_ctrl_fsm: directed vector table, hand-written
// corner sequences, then random stimulus against an instruction-level model.
module tb_mu0_ctrl_fsm;

    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic       pc_en;
        logic       ir_en;
        logic       acc_en;
        logic [1:0] m;
        logic       rd;
        logic       wr;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [3:0] f;
        logic       n;
        logic       z;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    function automatic outs_t mk(input logic x, input logic y, input logic a,
                                 input logic pc, input logic ir, input logic acc,
                                 input logic [1:0] m, input logic rd,
                                 input logic wr, input logic h);
        outs_t o;
        o = {x, y, a, pc, ir, acc, m, rd, wr, h};
        return o;
    endfunction

    localparam outs_t FETCH_O = mk(1, 0, 0, 1, 1, 0, 2'b10, 1, 0, 0);
    localparam outs_t LDA_O   = mk(0, 0, 1, 0, 0, 1, 2'b00, 1, 0, 0);
    localparam outs_t STA_O   = mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    localparam outs_t ADD_O   = mk(0, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0);
    localparam outs_t SUB_O   = mk(0, 0, 1, 0, 0, 1, 2'b11, 1, 0, 0);
    localparam outs_t JMP_O   = mk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    localparam outs_t IDLE_O  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    localparam outs_t HALT_O  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

`ifdef MU0_MEM_READY_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       r_rdy;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted;
    logic [1:0] M;
    outs_t      got;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 Clk = ~Clk;

    mu0_ctrl_fsm #(.OPW(4), .MW(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .F        (F),
        .N        (N),
        .Z        (Z),
`ifdef MU0_MEM_READY_EN
        .Mem_Rdy  (r_rdy),
`endif
        .X_sel    (X_sel),
        .Y_sel    (Y_sel),
        .Addr_sel (Addr_sel),
        .PC_En    (PC_En),
        .IR_En    (IR_En),
        .Acc_En   (Acc_En),
        .M        (M),
        .Rd       (Rd),
        .Wr       (Wr),
        .Halted   (Halted)
    );

    assign got = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted};

    task automatic check(input string name, input outs_t g, input outs_t e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (x,y,a,pc,ir,acc,m,rd,wr,h)", name, g, e);
        end
    endtask

    // Drive inputs just after a rising edge, check mid-cycle, then take the edge.
    task automatic step(input string name, input logic rst, input logic [3:0] f,
                        input logic n, input logic z, input logic rdy, input outs_t e);
        Reset = rst;
        F     = f;
        N     = n;
        Z     = z;
        r_rdy = rdy;
        @(negedge Clk);
        check(name, got, e);
        @(posedge Clk);
        #1;
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] f, input logic n,
                           input logic z, input outs_t e);
        vec_t v;
        v.rst = rst; v.f = f; v.n = n; v.z = z; v.rdy = 1'b1; v.exp = e;
        vecs.push_back(v);
    endtask

    // Instruction-level reference: what an MU0 cycle should ask of the datapath.
    function automatic outs_t model_out(input int ph, input logic [3:0] f,
                                        input logic n, input logic z, input logic rdy);
        outs_t o;
        logic  waiting;
        waiting = STALL_EN && !rdy;
        o = IDLE_O;
        if (ph == PH_FETCH) begin
            o = FETCH_O;
            if (waiting) begin
                o.pc_en = 1'b0;
                o.ir_en = 1'b0;
            end
        end else if (ph == PH_HALT) begin
            o = HALT_O;
        end else begin
            if (f == 4'd0)      o = LDA_O;
            else if (f == 4'd1) o = STA_O;
            else if (f == 4'd2) o = ADD_O;
            else if (f == 4'd3) o = SUB_O;
            else if (f == 4'd4 || (f == 4'd5 && !n) || (f == 4'd6 && !z)) o = JMP_O;
            if (waiting && f <= 4'd3) o.acc_en = 1'b0;
        end
        return o;
    endfunction

    function automatic int model_next(input int ph, input logic rst,
                                      input logic [3:0] f, input logic rdy);
        if (rst) return PH_FETCH;
        if (STALL_EN && !rdy && (ph == PH_FETCH || (ph == PH_EXEC && f <= 4'd3)))
            return ph;
        if (ph == PH_FETCH) return PH_EXEC;
        if (ph == PH_EXEC)  return (f == 4'd7) ? PH_HALT : PH_FETCH;
        return PH_HALT;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    ph;
        logic  rst_r, n_r, z_r, rdy_r;
        logic [3:0] f_r;
        outs_t e;

        // Two reset edges; outputs decode as FETCH while Reset stays high.
        Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; r_rdy = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("reset_state", got, FETCH_O);
        @(posedge Clk); #1;

        add_vec(0, 4'd0, 0, 0, FETCH_O); add_vec(0, 4'd0, 0, 0, LDA_O);
        add_vec(0, 4'd2, 0, 0, FETCH_O); add_vec(0, 4'd2, 0, 0, ADD_O);
        add_vec(0, 4'd1, 0, 0, FETCH_O); add_vec(0, 4'd1, 0, 0, STA_O);
        add_vec(0, 4'd3, 1, 1, FETCH_O); add_vec(0, 4'd3, 1, 1, SUB_O);
        add_vec(0, 4'd4, 1, 1, FETCH_O); add_vec(0, 4'd4, 1, 1, JMP_O);
        add_vec(0, 4'd5, 0, 1, FETCH_O); add_vec(0, 4'd5, 0, 1, JMP_O);
        add_vec(0, 4'd5, 1, 0, FETCH_O); add_vec(0, 4'd5, 1, 0, IDLE_O);
        add_vec(0, 4'd6, 0, 1, FETCH_O); add_vec(0, 4'd6, 0, 1, IDLE_O);
        add_vec(0, 4'd6, 1, 0, FETCH_O); add_vec(0, 4'd6, 1, 0, JMP_O);
        add_vec(0, 4'd9, 0, 0, FETCH_O); add_vec(0, 4'd9, 0, 0, IDLE_O);
        add_vec(0, 4'hF, 1, 1, FETCH_O); add_vec(0, 4'hF, 1, 1, IDLE_O);
        add_vec(0, 4'd0, 0, 0, FETCH_O);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].f, vecs[i].n,
                 vecs[i].z, vecs[i].rdy, vecs[i].exp);
        end
        // Last table row was a FETCH; finish that LDA so the next sequence starts in FETCH.
        step("vec_tail_lda", 0, 4'd0, 0, 0, 1, LDA_O);

        // STP, then HALT holds for ten cycles whatever the opcode, until Reset.
        step("stp_fetch", 0, 4'd7, 0, 0, 1, FETCH_O);
        step("stp_exec",  0, 4'd7, 0, 0, 1, IDLE_O);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("halt_hold%0d", i), 0, 4'(i), i[0], i[1], 1, HALT_O);
        end
        step("halt_reset_edge", 1, 4'd0, 0, 0, 1, HALT_O);
        step("after_halt_reset", 0, 4'd2, 0, 0, 1, FETCH_O);

        // Reset during ADD execute: back to FETCH, no accumulator load afterwards.
        step("add_exec_reset", 1, 4'd2, 0, 0, 1, ADD_O);
        step("post_reset_fetch", 0, 4'd9, 0, 0, 1, FETCH_O);
        step("noop_exec", 0, 4'd9, 0, 0, 1, IDLE_O);
        step("noop_back_fetch", 0, 4'd0, 0, 0, 1, FETCH_O);
        step("lda_again", 0, 4'd0, 0, 0, 1, LDA_O);

`ifdef MU0_MEM_READY_EN
        e = FETCH_O; e.pc_en = 1'b0; e.ir_en = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("fetch_stall%0d", i), 0, 4'd0, 0, 0, 0, e);
        step("fetch_ready", 0, 4'd0, 0, 0, 1, FETCH_O);
        e = LDA_O; e.acc_en = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("lda_stall%0d", i), 0, 4'd0, 0, 0, 0, e);
        step("lda_ready", 0, 4'd0, 0, 0, 1, LDA_O);
        step("jmp_fetch", 0, 4'd4, 0, 0, 1, FETCH_O);
        step("jmp_no_wait", 0, 4'd4, 0, 0, 0, JMP_O);
        step("after_jmp", 0, 4'd2, 0, 0, 1, FETCH_O);
        e = ADD_O; e.acc_en = 1'b0;
        step("reset_in_stall", 1, 4'd2, 0, 0, 0, e);
        e = FETCH_O; e.pc_en = 1'b0; e.ir_en = 1'b0;
        step("stall_after_reset", 0, 4'd2, 0, 0, 0, e);
        step("ready_after_reset", 0, 4'd2, 0, 0, 1, FETCH_O);
        step("add_done", 0, 4'd2, 0, 0, 1, ADD_O);
`endif

        // Random phase: start from a known reset, then let the model track the phase.
        step("rand_reset", 1, 4'd0, 0, 0, 1, FETCH_O);
        ph = PH_FETCH;
        for (int i = 0; i < 600; i++) begin
            rst_r = ($urandom_range(0, 19) == 0);
            f_r   = 4'($urandom_range(0, 15));
            if (f_r == 4'd7 && $urandom_range(0, 3) != 0) f_r = 4'd2;
            n_r   = 1'($urandom_range(0, 1));
            z_r   = 1'($urandom_range(0, 1));
            rdy_r = ($urandom_range(0, 3) != 0);
            e     = model_out(ph, f_r, n_r, z_r, rdy_r);
            step($sformatf("rand%0d_ph%0d_f%0d", i, ph, f_r), rst_r, f_r, n_r, z_r, rdy_r, e);
            ph    = model_next(ph, rst_r, f_r, rdy_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
